// File: rtl/mux_pkg.sv
// Shared types and helpers for the pipelined selector family.
// Imported by pipe_mux_n and mux_sel_comb.
package mux_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam int MUX_MAX_IN = 16;

    function automatic int sel_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mux_sel_comb.sv
// Combinational N:1 lane select with an out-of-range flag.
// An out-of-range select yields all-zero data.
module mux_sel_comb
    import mux_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 2,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    sel_err
);

    always_comb begin
        out_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (32'(sel) == i) begin
                out_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Constant-false when NUM_IN is a power of two.
    assign sel_err = (32'(sel) >= 32'(NUM_IN));

endmodule

// File: rtl/pipe_mux_n.sv
// N:1 selector with registered output and a 2-entry skid buffer.
// Select and data are captured together; in_ready is a register.
module pipe_mux_n
    import mux_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 2,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    state_t state, next_state;

    logic [WIDTH-1:0] pick_data;
    logic             pick_err;

    logic [WIDTH-1:0] m_data, s_data;
    logic [SEL_W-1:0] m_sel, s_sel;
    logic             in_ready_r;
    logic             sel_err_r;

    logic accept, emit;
    logic load_m, load_s, shift_s;

    mux_sel_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_sel (
        .in_data  (in_data),
        .sel      (sel),
        .out_data (pick_data),
        .sel_err  (pick_err)
    );

    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid & in_ready_r;
    assign emit      = out_valid & out_ready;

    always_comb begin
        next_state = state;
        load_m     = 1'b0;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_m     = 1'b1;
                    next_state = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && emit) begin
                    load_m = 1'b1;
                end else if (accept) begin
                    load_s     = 1'b1;
                    next_state = ST_TWO;
                end else if (emit) begin
                    next_state = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (emit) begin
                    shift_s    = 1'b1;
                    next_state = ST_ONE;
                end
            end
            default: next_state = ST_EMPTY;
        endcase
    end

    // M only changes on emit or when empty, so held output stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_EMPTY;
            in_ready_r <= 1'b1;
            sel_err_r  <= 1'b0;
            m_data     <= '0;
            m_sel      <= '0;
            s_data     <= '0;
            s_sel      <= '0;
        end else begin
            state      <= next_state;
            in_ready_r <= (next_state != ST_TWO);
            sel_err_r  <= accept & pick_err;
            if (load_m) begin
                m_data <= pick_data;
                m_sel  <= sel;
            end else if (shift_s) begin
                m_data <= s_data;
                m_sel  <= s_sel;
            end
            if (load_s) begin
                s_data <= pick_data;
                s_sel  <= sel;
            end
        end
    end

    assign in_ready = in_ready_r;
    assign out_data = m_data;
    assign out_sel  = m_sel;
    assign sel_err  = sel_err_r;

endmodule

// File: tb/tb_pipe_mux_n.sv
// Directed self-checking bench for pipe_mux_n: 4-lane, 3-lane and
// 5-bit 2-lane instances sharing one clock and reset.
module tb_pipe_mux_n;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic [127:0] d4;
    logic [1:0]   sel4, os4;
    logic         v4, r4, ov4, ordy4, err4;
    logic [31:0]  od4;

    logic [95:0]  d3;
    logic [1:0]   sel3, os3;
    logic         v3, r3, ov3, ordy3, err3;
    logic [31:0]  od3;

    logic [9:0]   d5;
    logic [0:0]   sel5, os5;
    logic         v5, r5, ov5, ordy5, err5;
    logic [4:0]   od5;

    int checks = 0;
    int errors = 0;

    pipe_mux_n #(.WIDTH(32), .NUM_IN(4)) u4 (
        .clk(clk), .rst(rst), .in_data(d4), .sel(sel4), .in_valid(v4),
        .in_ready(r4), .out_data(od4), .out_sel(os4), .out_valid(ov4),
        .out_ready(ordy4), .sel_err(err4)
    );

    pipe_mux_n #(.WIDTH(32), .NUM_IN(3)) u3 (
        .clk(clk), .rst(rst), .in_data(d3), .sel(sel3), .in_valid(v3),
        .in_ready(r3), .out_data(od3), .out_sel(os3), .out_valid(ov3),
        .out_ready(ordy3), .sel_err(err3)
    );

    pipe_mux_n #(.WIDTH(5), .NUM_IN(2)) u5 (
        .clk(clk), .rst(rst), .in_data(d5), .sel(sel5), .in_valid(v5),
        .in_ready(r5), .out_data(od5), .out_sel(os5), .out_valid(ov5),
        .out_ready(ordy5), .sel_err(err5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] lane4 [4];

    initial begin
        lane4[0] = 32'h11111111;
        lane4[1] = 32'h22222222;
        lane4[2] = 32'h33333333;
        lane4[3] = 32'h44444444;

        rst   = 1'b1;
        d4    = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        sel4  = '0; v4 = 1'b0; ordy4 = 1'b1;
        d3    = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        sel3  = '0; v3 = 1'b0; ordy3 = 1'b1;
        d5    = {5'd17, 5'd8};
        sel5  = '0; v5 = 1'b0; ordy5 = 1'b1;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // asynchronous reset pulse between clock edges
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, ov4}, 32'd0);
        check("rst_out_data",  od4, 32'd0);
        check("rst_out_sel",   {30'd0, os4}, 32'd0);
        check("rst_in_ready",  {31'd0, r4}, 32'd1);
        check("rst_sel_err",   {31'd0, err4}, 32'd0);
        #1 rst = 1'b0;

        // streaming, one beat per cycle
        step();
        v4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel4 = 2'(k);
            step();
            check($sformatf("stream_data%0d", k), od4, lane4[k]);
            check($sformatf("stream_sel%0d", k), {30'd0, os4}, 32'(k));
            check($sformatf("stream_valid%0d", k), {31'd0, ov4}, 32'd1);
            check($sformatf("stream_ready%0d", k), {31'd0, r4}, 32'd1);
        end
        v4 = 1'b0;
        step();
        check("stream_drain_valid", {31'd0, ov4}, 32'd0);

        // back-pressure: three beats offered, two fit
        ordy4 = 1'b0; v4 = 1'b1; sel4 = 2'd0;
        step();
        check("bp_first_data", od4, 32'h11111111);
        check("bp_first_ready", {31'd0, r4}, 32'd1);
        sel4 = 2'd1;
        step();
        check("bp_full_ready", {31'd0, r4}, 32'd0);
        check("bp_full_hold", od4, 32'h11111111);
        sel4 = 2'd2;
        step();
        check("bp_stall_hold", od4, 32'h11111111);
        check("bp_stall_sel", {30'd0, os4}, 32'd0);
        check("bp_stall_ready", {31'd0, r4}, 32'd0);
        ordy4 = 1'b1;
        step();
        check("bp_rel_data1", od4, 32'h22222222);
        check("bp_rel_ready", {31'd0, r4}, 32'd1);
        step();
        check("bp_rel_data2", od4, 32'h33333333);
        check("bp_rel_sel2", {30'd0, os4}, 32'd2);
        v4 = 1'b0;
        step();
        check("bp_drain_valid", {31'd0, ov4}, 32'd0);

        // reset while both registers are full
        ordy4 = 1'b0; v4 = 1'b1; sel4 = 2'd3;
        step();
        sel4 = 2'd2;
        step();
        check("mid_two_ready", {31'd0, r4}, 32'd0);
        check("mid_two_data", od4, 32'h44444444);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, ov4}, 32'd0);
        check("mid_rst_ready", {31'd0, r4}, 32'd1);
        check("mid_rst_data", od4, 32'd0);
        sel4 = 2'd1;
        step();
        rst = 1'b0; v4 = 1'b0; ordy4 = 1'b1;
        check("rst_wins_valid", {31'd0, ov4}, 32'd0);
        step();
        check("post_rst_idle", {31'd0, ov4}, 32'd0);
        v4 = 1'b1; sel4 = 2'd1;
        step();
        check("post_rst_valid", {31'd0, ov4}, 32'd1);
        check("post_rst_data", od4, 32'h22222222);
        v4 = 1'b0;
        step();
        check("post_rst_drain", {31'd0, ov4}, 32'd0);

        // out-of-range select on the 3-lane instance
        v3 = 1'b1; sel3 = 2'd3;
        step();
        check("oor_data", od3, 32'd0);
        check("oor_sel", {30'd0, os3}, 32'd3);
        check("oor_err", {31'd0, err3}, 32'd1);
        check("oor_valid", {31'd0, ov3}, 32'd1);
        sel3 = 2'd2;
        step();
        check("oor_next_data", od3, 32'hCCCCCCCC);
        check("oor_err_pulse", {31'd0, err3}, 32'd0);
        v3 = 1'b0;
        step();
        check("oor_drain", {31'd0, ov3}, 32'd0);
        check("oor_err_idle", {31'd0, err3}, 32'd0);

        // 5-bit register-index selector
        v5 = 1'b1; sel5 = 1'b1;
        step();
        check("idx_rd", {27'd0, od5}, 32'd17);
        check("idx_rd_sel", {31'd0, os5}, 32'd1);
        sel5 = 1'b0;
        step();
        check("idx_rt", {27'd0, od5}, 32'd8);
        check("idx_err", {31'd0, err5}, 32'd0);
        v5 = 1'b0;
        step();
        check("idx_drain", {31'd0, ov5}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_mux_n.md
Name: pipe_mux_n

Overview:
- Parametrised N:1 datapath multiplexer with a registered output and a valid/ready handshake. Successor to the 2:1 32-bit and 5-bit selectors in the MIPS datapath.
- Selection is sampled together with the input data, so input changes and select changes can never race.
- Carries a 2-entry skid buffer, so `in_ready` is a register and back-pressure never combinationally chains between pipeline stages.
- Used between pipeline stages: ALU-source select, write-back select, register-destination select.

Parameters:
- WIDTH, 32, data width per input (5 for register-index selection).
- NUM_IN, 2, number of inputs; legal range 2..16.
- SEL_W, $clog2(NUM_IN), selector width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  selects the input; sampled with in_data
- in_valid  in  1  in_data/sel are valid this cycle
- in_ready  out  1  block accepts a beat this cycle (registered)
- out_data  out  WIDTH  selected data
- out_sel  out  SEL_W  selector value that produced out_data
- out_valid  out  1  out_data/out_sel are valid
- out_ready  in  1  consumer accepts the beat this cycle
- sel_err  out  1  one-cycle pulse: an accepted beat had sel >= NUM_IN

Behaviour:
- Reset is asynchronous, active-high: clk and rst; rst asserted clears the state immediately, independent of clk.
  - Reset values: out_valid=0, out_data=0, out_sel=0, in_ready=1 (after reset), sel_err=0, skid entry empty.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- Latency: 1 cycle. A beat accepted on edge N appears on out_data at edge N+1 when the main register is free.
- Beats leave in acceptance order; none are dropped or duplicated.
- Selection rules:
  - Selected value = in_data[sel*WIDTH +: WIDTH].
  - sel >= NUM_IN (only possible when NUM_IN is not a power of 2): stored data = 0, sel_err pulses high for exactly the cycle after acceptance. The beat is still delivered.
- State machine (main register M, skid register S):
  - EMPTY: out_valid=0, in_ready=1. Accept -> load M -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept & Emit -> load M with new beat, stay ONE.
    - Accept & !Emit -> load S -> TWO.
    - !Accept & Emit -> EMPTY.
    - Otherwise hold.
  - TWO: out_valid=1, in_ready=0.
    - Emit -> M <= S -> ONE.
    - No accept is possible in TWO.
- in_ready is a registered output and equals (next_state != TWO).
- Stability rule: while out_valid=1 and out_ready=0, out_data and out_sel must not change.
- in_valid may drop without a handshake. Inputs are ignored whenever in_ready=0.
- A reset mid-transfer discards the contents of M and S. No beat is emitted after rst deasserts until a new accept occurs.
- Simultaneous rst and in_valid: reset wins and nothing is accepted.

Decomposition:
- Shared package mux_pkg:
  - state enum {ST_EMPTY, ST_ONE, ST_TWO}, 2-bit encoding.
  - MUX_MAX_IN = 16.
  - Function sel_width(n) = $clog2(n).
- One sub-module: mux_sel_comb (WIDTH, NUM_IN). Pure combinational N:1 select with a range-error flag.
  - Reused by the forwarding unit.
  - The top level instantiates it once, ahead of the input register.

Test Plan:
- Reset then idle: rst pulse mid-cycle (no clk edge) -> out_valid=0, out_data=0, in_ready=1 immediately.
- Streaming: WIDTH=32, NUM_IN=4, out_ready=1; beats sel=0..3 with in_data lanes 0x11111111, 0x22222222, 0x33333333, 0x44444444 each cycle -> out_data follows one cycle later in the same order; in_ready stays 1.
- Back-pressure: out_ready=0 while 3 beats are offered -> 2 beats accepted, in_ready=0 from the cycle after the 2nd accept, out_data held at the 1st beat. Release out_ready -> remaining beats emerge in order, none lost.
- Out-of-range select: NUM_IN=3, sel=3 accepted -> out_data=0, out_sel=3, sel_err high for exactly 1 cycle.
- Reset mid-operation: state TWO (out_ready=0) then rst=1 for 1 cycle -> out_valid=0, in_ready=1. The next out beat is the first one accepted after reset.
- 5-bit instance: WIDTH=5, NUM_IN=2; rt=5'd8 on input 0, rd=5'd17 on input 1, sel=1 -> out_data=17 after 1 cycle.
